// File: rtl/shift_word_collector_if.sv
// Output stream of the shift word collector.
//   out_data  : head word of the collector's output queue (0 when empty)
//   out_valid : out_data holds a valid word
//   out_ready : consumer accepts the head word when out_valid is also high
// The collector drives the master modport; the consumer uses the slave modport.
interface shift_word_collector_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/shift_word_collector.sv
// Serial-to-parallel collector fed by the LSB of an upstream right shifter.
// Bits arrive LSB first. They are reassembled into WIDTH-bit words, and the
// words are buffered in a 2-entry FIFO that has a valid/ready output.
// Ports:
//   clk      : system clock, rising edge
//   rst      : asynchronous active-high reset
//   ser_in   : serial data bit
//   ser_vld  : ser_in is sampled this cycle
//   sync     : word-boundary restart that discards the partial word
//   bit_cnt  : bits held in the current partial word
//   ovf      : sticky flag, set when a completed word was dropped
//   clr_ovf  : synchronous clear of ovf
//   out      : output stream (out_data / out_valid / out_ready)
module shift_word_collector #(
  parameter  int WIDTH = 4,
  localparam int CW    = $clog2(WIDTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ser_in,
  input  logic                   ser_vld,
  input  logic                   sync,
  output logic [CW-1:0]          bit_cnt,
  output logic                   ovf,
  input  logic                   clr_ovf,
  shift_word_collector_if.master out
);

  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] asm;
  // q0 is the head entry. Each entry is kept at 0 while it is not valid, so
  // out_data can be driven directly from q0.
  logic [WIDTH-1:0] q0;
  logic [WIDTH-1:0] q1;
  logic             v0;
  logic             v1;

  logic [WIDTH-1:0] word;
  logic             done;
  logic             pop;
  logic [WIDTH-1:0] q0_n;
  logic [WIDTH-1:0] q1_n;
  logic             v0_n;
  logic             v1_n;
  logic             drop;

  assign out.out_data  = q0;
  assign out.out_valid = v0;

  // Work out whether a word completes, whether the head pops, and the next queue state.
  always_comb begin
    word = {ser_in, asm[WIDTH-1:1]};
    // With sync set, the incoming bit starts a new word and so can never complete one.
    done = ser_vld && !sync && (bit_cnt == LAST_IDX);
    // out_ready is ignored while the queue is empty.
    pop  = v0 && out.out_ready;
    q0_n = q0;
    q1_n = q1;
    v0_n = v0;
    v1_n = v1;
    drop = 1'b0;
    case ({done, pop})
      2'b01: begin
        q0_n = q1;
        v0_n = v1;
        q1_n = {WIDTH{1'b0}};
        v1_n = 1'b0;
      end
      2'b10: begin
        if (!v0) begin
          q0_n = word;
          v0_n = 1'b1;
        end else if (!v1) begin
          q1_n = word;
          v1_n = 1'b1;
        end else begin
          // The queue is full and nothing leaves it: drop the new word and keep the contents.
          drop = 1'b1;
        end
      end
      2'b11: begin
        // A pop implies v0 is set. The pop frees a slot, so the push always fits.
        if (v1) begin
          q0_n = q1;
          q1_n = word;
        end else begin
          q0_n = word;
          q1_n = {WIDTH{1'b0}};
        end
      end
      default: begin
        q0_n = q0;
        q1_n = q1;
      end
    endcase
  end

  // Register the assembly shift register and the bit counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm     <= {WIDTH{1'b0}};
      bit_cnt <= CNT_ZERO;
    end else if (ser_vld) begin
      if (sync) begin
        // Restart: the incoming bit becomes bit 0 of a new word and will shift down into asm[0].
        asm     <= {ser_in, {(WIDTH-1){1'b0}}};
        bit_cnt <= CNT_ONE;
      end else begin
        asm     <= word;
        bit_cnt <= (bit_cnt == LAST_IDX) ? CNT_ZERO : (bit_cnt + CNT_ONE);
      end
    end else if (sync) begin
      asm     <= {WIDTH{1'b0}};
      bit_cnt <= CNT_ZERO;
    end else begin
      asm     <= asm;
      bit_cnt <= bit_cnt;
    end
  end

  // Register the output queue entries and their valid flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q0 <= {WIDTH{1'b0}};
      q1 <= {WIDTH{1'b0}};
      v0 <= 1'b0;
      v1 <= 1'b0;
    end else begin
      q0 <= q0_n;
      q1 <= q1_n;
      v0 <= v0_n;
      v1 <= v1_n;
    end
  end

  // Register the sticky overflow flag. A drop takes priority over a clear in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (clr_ovf) begin
      ovf <= 1'b0;
    end else begin
      ovf <= ovf;
    end
  end

endmodule

// File: tb/tb_shift_word_collector.sv
// Self-checking bench for shift_word_collector with WIDTH=4: directed scenarios
// followed by random traffic, all compared against a queue-based reference model.
module tb_shift_word_collector;

  localparam int W  = 4;
  localparam int CW = $clog2(W) + 1;

  logic          clk;
  logic          rst;
  logic          ser_in;
  logic          ser_vld;
  logic          sync;
  logic          clr_ovf;
  logic [CW-1:0] bit_cnt;
  logic          ovf;

  shift_word_collector_if #(.WIDTH(W)) bus ();

  shift_word_collector #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .ser_in  (ser_in),
    .ser_vld (ser_vld),
    .sync    (sync),
    .bit_cnt (bit_cnt),
    .ovf     (ovf),
    .clr_ovf (clr_ovf),
    .out     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the partial word is kept as a plain integer plus a bit count.
  int m_q[$];
  int m_val;
  int m_cnt;
  bit m_ovf;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_val = 0;
    m_cnt = 0;
    m_ovf = 1'b0;
  endtask

  task automatic model_step(input bit si, input bit sv, input bit sy, input bit rdy, input bit co);
    bit do_pop;
    bit do_push;
    bit ovf_ev;
    int w;
    do_pop  = (m_q.size() > 0) && rdy;
    do_push = 1'b0;
    ovf_ev  = 1'b0;
    w       = 0;
    if (sv) begin
      if (sy) begin
        m_val = int'(si);
        m_cnt = 1;
      end else begin
        m_val = m_val + (int'(si) << m_cnt);
        m_cnt++;
        if (m_cnt == W) begin
          do_push = 1'b1;
          w       = m_val;
          m_val   = 0;
          m_cnt   = 0;
        end
      end
    end else if (sy) begin
      m_val = 0;
      m_cnt = 0;
    end
    if (do_pop) void'(m_q.pop_front());
    if (do_push) begin
      if (m_q.size() < 2) m_q.push_back(w);
      else ovf_ev = 1'b1;
    end
    if (ovf_ev) m_ovf = 1'b1;
    else if (co) m_ovf = 1'b0;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".valid"}, 32'(bus.out_valid), (m_q.size() > 0) ? 32'd1 : 32'd0);
    check({tag, ".data"},  32'(bus.out_data),  (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0);
    check({tag, ".bitcnt"}, 32'(bit_cnt), 32'(m_cnt));
    check({tag, ".ovf"},   32'(ovf), 32'(m_ovf));
  endtask

  // Drive one cycle of inputs, advance the model and the DUT, then compare just after the edge.
  task automatic step(input bit si, input bit sv, input bit sy, input bit rdy, input bit co,
                      input string tag);
    ser_in        = si;
    ser_vld       = sv;
    sync          = sy;
    bus.out_ready = rdy;
    clr_ovf       = co;
    model_step(si, sv, sy, rdy, co);
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  // Send a word LSB first. rdy_last sets out_ready on the completing bit only; co_last does the same for clr_ovf.
  task automatic send_word(input logic [3:0] w, input bit rdy_last, input bit co_last, input string tag);
    for (int i = 0; i < W; i++) begin
      step(w[i], 1'b1, 1'b0, (i == W - 1) ? rdy_last : 1'b0, (i == W - 1) ? co_last : 1'b0, tag);
    end
  endtask

  task automatic idle(input bit rdy, input bit co, input string tag);
    step(1'b0, 1'b0, 1'b0, rdy, co, tag);
  endtask

  initial begin
    rst = 1'b1;
    ser_in = 1'b0; ser_vld = 1'b0; sync = 1'b0; clr_ovf = 1'b0; bus.out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model("reset");
    #3 rst = 1'b0;

    // A single word 0,0,1,0 gives 4'h4. It appears right after the fourth bit and leaves on the next pop.
    send_word(4'h4, 1'b0, 1'b0, "w1");
    check("w1.data_is_4", 32'(bus.out_data), 32'h4);
    check("w1.valid_up", 32'(bus.out_valid), 32'd1);
    idle(1'b1, 1'b0, "w1pop");
    check("w1.valid_down", 32'(bus.out_valid), 32'd0);

    // Two back-to-back words, then drain the queue in FIFO order.
    send_word(4'h2, 1'b0, 1'b0, "b2a");
    send_word(4'hF, 1'b0, 1'b0, "b2b");
    check("b2.head_2", 32'(bus.out_data), 32'h2);
    idle(1'b1, 1'b0, "b2pop1");
    check("b2.head_F", 32'(bus.out_data), 32'hF);
    idle(1'b1, 1'b0, "b2pop2");
    check("b2.empty", 32'(bus.out_valid), 32'd0);

    // Overflow on a full queue, then a push that coincides with a pop while full.
    send_word(4'h2, 1'b0, 1'b0, "ofa");
    send_word(4'hF, 1'b0, 1'b0, "ofb");
    send_word(4'h1, 1'b0, 1'b0, "ofc");
    check("of.ovf_set", 32'(ovf), 32'd1);
    check("of.head_kept", 32'(bus.out_data), 32'h2);
    idle(1'b0, 1'b1, "ofclr");
    check("of.ovf_clr", 32'(ovf), 32'd0);
    send_word(4'h1, 1'b1, 1'b0, "ofd");
    check("of.no_ovf", 32'(ovf), 32'd0);
    check("of.head_F", 32'(bus.out_data), 32'hF);
    idle(1'b1, 1'b0, "ofpop1");
    check("of.head_1", 32'(bus.out_data), 32'h1);
    idle(1'b1, 1'b0, "ofpop2");

    // sync with ser_vld restarts the word with the current bit.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "sy1");
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "sy2");
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "sy3");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "sy4");
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "sy5");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "sy6");
    check("sy.data_4", 32'(bus.out_data), 32'h4);
    check("sy.cnt_0", 32'(bit_cnt), 32'd0);
    idle(1'b1, 1'b0, "sypop");
    // sync without ser_vld after three bits clears the partial word and pushes nothing.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "sz1");
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "sz2");
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "sz3");
    check("sz.cnt_3", 32'(bit_cnt), 32'd3);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "sz4");
    check("sz.cnt_0", 32'(bit_cnt), 32'd0);
    check("sz.no_push", 32'(bus.out_valid), 32'd0);

    // Overflow in the same cycle as clr_ovf: the set wins.
    send_word(4'h3, 1'b0, 1'b0, "oca");
    send_word(4'h6, 1'b0, 1'b0, "ocb");
    send_word(4'h9, 1'b0, 1'b0, "occ");
    idle(1'b0, 1'b1, "occlr");
    check("oc.cleared", 32'(ovf), 32'd0);
    send_word(4'hA, 1'b0, 1'b1, "ocd");
    check("oc.set_wins", 32'(ovf), 32'd1);

    // Asynchronous reset in mid-cycle with three bits pending and the queue full.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "ra1");
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "ra2");
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "ra3");
    ser_vld = 1'b0;
    #3 rst = 1'b1;
    #1;
    model_reset();
    check("rst.valid", 32'(bus.out_valid), 32'd0);
    check("rst.data", 32'(bus.out_data), 32'd0);
    check("rst.cnt", 32'(bit_cnt), 32'd0);
    check("rst.ovf", 32'(ovf), 32'd0);
    #2 rst = 1'b0;
    send_word(4'h5, 1'b0, 1'b0, "post");
    check("post.data_5", 32'(bus.out_data), 32'h5);
    idle(1'b1, 1'b0, "postpop");

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)),
           ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 5)  ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 40) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 5)  ? 1'b1 : 1'b0,
           "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_word_collector.md
Name: shift_word_collector

Overview:
- Serial-to-parallel stage directly downstream of the 4-bit right shift register.
- Consumes the bit the shifter emits from its LSB on each enabled shift, LSB first.
- Reassembles WIDTH-bit words and buffers them in a 2-entry output queue with a valid/ready handshake.
- Flags dropped words with a sticky overflow bit.

Parameters:
- WIDTH, 4, bits per reassembled word; legal values are 2 to 16.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- ser_in  input  1  serial bit from the upstream shifter LSB.
- ser_vld  input  1  ser_in is sampled this cycle; driven from the shifter's shift-enable.
- sync  input  1  word-boundary restart: discards the partial word.
- out_data  output  WIDTH  head word of the output queue.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  consumer accepts the head word when out_valid is also high.
- bit_cnt  output  clog2(WIDTH)+1  number of bits accumulated in the current partial word.
- ovf  output  1  sticky: a completed word was dropped.
- clr_ovf  input  1  synchronous clear of ovf.

Behaviour:
- Reset (asynchronous, rst=1): assembly register=0, bit_cnt=0, queue empty, out_valid=0, out_data=0, ovf=0. No stale word appears after rst deasserts.
- Assembly on a ser_vld=1 cycle:
  - asm <= {ser_in, asm[WIDTH-1:1]} (right shift, new bit enters at MSB).
  - bit_cnt increments.
  - After WIDTH accepted bits, asm[0] holds the first bit received and asm[WIDTH-1] the last.
- Word completion: when bit_cnt==WIDTH-1 and ser_vld=1, the completed word {ser_in, asm[WIDTH-1:1]} is pushed at that same edge and bit_cnt returns to 0.
- Latency: out_valid rises on the cycle after the edge that accepted the last bit, when the queue was empty.
- ser_vld=0: asm and bit_cnt hold.
- sync=1 with ser_vld=0: bit_cnt <= 0, asm <= 0.
- sync=1 with ser_vld=1: the partial word is discarded and ser_in becomes bit 0 of a new word (bit_cnt <= 1).
- sync never affects the queue or ovf.
- Queue: 2 entries, FIFO order; out_data always shows the head entry (0 when empty).
  - Pop occurs when out_valid && out_ready.
  - out_ready while out_valid=0 is ignored.
- Simultaneous push and pop:
  - Empty queue: no pop is possible; push only.
  - One entry: the head pops and the new word becomes head; out_valid stays 1.
  - Full queue: the pop frees a slot and the push is accepted; no overflow.
- Overflow: push while full with no pop drops the new word. Queue contents are unchanged and ovf <= 1.
- clr_ovf=1 clears ovf. If clr_ovf=1 and an overflow occur in the same cycle, set wins and ovf stays 1.
- Reset asserted mid-word or with a non-empty queue: all state cleared immediately and asynchronously. The partial word and queued words are lost.
- Outputs are registered; no combinational path from ser_in, ser_vld or sync to any output. out_valid and out_data depend only on queue state.
- Combinational path exists from out_ready into queue pointer update only.

Test Plan:
- WIDTH=4, reset released, ser_vld=1 for 4 cycles with ser_in=0,0,1,0 -> out_valid=1 one cycle after the 4th bit, out_data=4'h4. With out_ready=1, out_valid drops the next cycle.
- Two words back-to-back with out_ready=0: bits 0,1,0,0 then 1,1,1,1 -> head out_data=4'h2, out_valid=1. Assert out_ready for one cycle -> out_data=4'hF. Next pop -> out_valid=0.
- Queue full (4'h2, 4'hF), out_ready=0, third word 1,0,0,0 completes -> ovf=1, out_data still 4'h2, queue depth 2. Repeat with out_ready=1 on the completing cycle -> no ovf, queue holds 4'hF, 4'h1.
- Two bits sent (1,1), then sync with ser_vld=1, ser_in=0, then 0,1,0 -> out_data=4'h4 and bit_cnt=0 afterwards. Sync with ser_vld=0 after 3 bits -> bit_cnt=0 and no word pushed.
- ovf=1, then pulse clr_ovf -> ovf=0. Force an overflow in the same cycle as clr_ovf=1 -> ovf=1.
- Assert rst asynchronously, mid-clock, with bit_cnt=3 and 2 queued words -> out_valid=0, out_data=0, bit_cnt=0, ovf=0 immediately. After release, a fresh 4-bit word 1,0,1,0 -> out_data=4'h5.
